// File: rtl/seg_pkg.sv
// seg_pkg: active-low seven-segment patterns ({g,f,e,d,c,b,a}) and pattern-to-hex decode
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct packed {
    logic       legal;
    logic [3:0] hex;
  } seg_dec_t;
  function automatic seg_dec_t seg_decode(input logic [6:0] s);
    seg_decode = '{legal: 1'b0, hex: 4'h0};
    for (int i = 0; i < 16; i++)
      if (s == SEG_PAT[i]) seg_decode = '{legal: 1'b1, hex: 4'(i)};
  endfunction
endpackage

// File: rtl/seg_settle_filter.sv
// seg_settle_filter: synchronizes {an,seg} and strobes one sample per stable window
module seg_settle_filter #(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] an_in,
  output logic                  sample,
  output logic [NUM_DIGITS-1:0] an_s,
  output logic [6:0]            seg_s
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES - 1);
  logic [W-1:0]  s1, s2;
  logic [CW-1:0] cnt;
  logic          taken;
  // two-flop synchronizer; idles at all-ones (nothing lit)
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {an_in, seg_in};
      s2 <= s1;
    end
  // settle counter restarts on the edge where the synchronized value changes
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      cnt   <= '0;
      taken <= 1'b0;
    end else if (s1 != s2) begin
      cnt   <= '0;
      taken <= 1'b0;
    end else begin
      cnt   <= cnt == CMAX ? cnt : cnt + CW'(1);
      taken <= taken | sample;
    end
  assign sample        = cnt == CMAX && !taken;
  assign {an_s, seg_s} = s2;
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed SEG/AN scan into digit frames; SEG_ERR_CNT_EN adds err_count
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic                    frame_done,
  output logic                    decode_err,
`ifdef SEG_ERR_CNT_EN
  output logic [7:0]              err_count,
`endif
  output logic                    stale
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [1:0]            rst_ff;
  logic                  rst;
  logic                  sample;
  logic [NUM_DIGITS-1:0] an_s, seen, hit;
  logic [6:0]            seg_s;
  seg_dec_t              dec;
  logic                  is_blank, one_hot, good, err_ev;
  logic [TW-1:0]         tcnt;
  // asserts immediately, releases two clocks after reset drops
  always_ff @(posedge CLK100MHZ or posedge reset)
    if (reset) rst_ff <= '1;
    else rst_ff <= {rst_ff[0], 1'b0};
  assign rst = rst_ff[1];
  seg_settle_filter #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_filter (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .seg_in   (seg_in),
    .an_in    (an_in),
    .sample   (sample),
    .an_s     (an_s),
    .seg_s    (seg_s)
  );
  // classify a sample: good capture, blanking interval, or decode error
  always_comb begin
    dec      = seg_decode(seg_s);
    is_blank = seg_s == SEG_BLANK;
    one_hot  = $onehot(~an_s);
    good     = sample && one_hot && (is_blank || dec.legal);
    err_ev   = sample && !(&an_s) && !(one_hot && (is_blank || dec.legal));
    hit      = good ? ~an_s : '0;
  end
  // store the captured digit; a blank keeps the previous hex value
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      digits_out <= '0;
      blank_out  <= '0;
      valid_out  <= '0;
    end else begin
      valid_out <= valid_out | hit;
      blank_out <= (blank_out & ~hit) | (is_blank ? hit : '0);
      for (int k = 0; k < NUM_DIGITS; k++)
        if (hit[k] && !is_blank) digits_out[4*k +: 4] <= dec.hex;
    end
  // frame tracking; a capture in the clearing cycle survives into the new mask
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      seen       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= &seen;
      seen       <= ((&seen) ? '0 : seen) | hit;
    end
  // sticky error flag and saturating time-since-capture counter
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      decode_err <= 1'b0;
      tcnt       <= '0;
    end else begin
      decode_err <= decode_err | err_ev;
      tcnt       <= good ? '0 : tcnt == TMAX ? tcnt : tcnt + TW'(1);
    end
  assign stale = tcnt == TMAX;
`ifdef SEG_ERR_CNT_EN
  // saturating count of decode error events
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) err_count <= '0;
    else if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table-driven scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;
  localparam int N  = 8;
  localparam int TO = 300;
  localparam logic [6:0] PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct {
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic [4*N-1:0] dig;
    logic [N-1:0]   blk;
    logic [N-1:0]   vld;
  } vec_t;
  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     seg_in;
  logic [N-1:0]   an_in;
  logic [4*N-1:0] digits_out;
  logic [N-1:0]   blank_out, valid_out;
  logic           frame_done, decode_err, stale;
`ifdef SEG_ERR_CNT_EN
  logic [7:0]     err_count;
`endif
  int   n_vec = 0;
  int   n_bad = 0;
  int   fd_cnt = 0;
  int   fd0;
  vec_t tbl [8];
  vec_t q [$];
  vec_t e;

  seg_scan_decoder #(.NUM_DIGITS(N), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .digits_out(digits_out),
    .blank_out (blank_out),
    .valid_out (valid_out),
    .frame_done(frame_done),
    .decode_err(decode_err),
`ifdef SEG_ERR_CNT_EN
    .err_count (err_count),
`endif
    .stale     (stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frame_done) fd_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] an, input logic [6:0] seg, input int hold);
    an_in  = an;
    seg_in = seg;
    repeat (hold) @(negedge clk);
  endtask

  task automatic scan(input int k, input int v, input int hold);
    drive(~(N'(1) << k), PAT[v], hold);
  endtask

  task automatic hit_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_digits", digits_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_blank", blank_out, 0);
    chk("rst_err", decode_err, 0);
    chk("rst_stale", stale, 0);
    chk("rst_frame", frame_done, 0);
`ifdef SEG_ERR_CNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{8'hFD, 7'h79, 32'h0000_0012, 8'h00, 8'h03};
    tbl[1] = '{8'hFB, 7'h7F, 32'h0000_0012, 8'h04, 8'h07};
    tbl[2] = '{8'hF7, 7'h0E, 32'h0000_F012, 8'h04, 8'h0F};
    tbl[3] = '{8'hFF, 7'h7F, 32'h0000_F012, 8'h04, 8'h0F};
    tbl[4] = '{8'hFB, 7'h08, 32'h0000_FA12, 8'h00, 8'h0F};
    tbl[5] = '{8'h7F, 7'h21, 32'hD000_FA12, 8'h00, 8'h8F};
    tbl[6] = '{8'hFE, 7'h7F, 32'hD000_FA12, 8'h01, 8'h8F};
    tbl[7] = '{8'hFE, 7'h03, 32'hD000_FA1B, 8'h00, 8'h8F};
    reset  = 1'b1;
    an_in  = '1;
    seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_digits", digits_out, 0);
    chk("idle_valid", valid_out, 0);
    chk("idle_blank", blank_out, 0);
    chk("idle_err", decode_err, 0);
    chk("idle_stale", stale, 0);
    chk("idle_frames", fd_cnt, 0);
    drive(8'hFD, 7'h79, 10);
    drive(8'hFE, 7'h24, 17);
    chk("glitch_valid", valid_out, 0);
    chk("early_digit", digits_out, 0);
    @(negedge clk);
    chk("latency_digit", digits_out[3:0], 4'h2);
    chk("latency_valid", valid_out, 8'h01);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      an_in  = tbl[i].an;
      seg_in = tbl[i].seg;
      q.push_back(tbl[i]);
      repeat (30) @(negedge clk);
      e = q.pop_front();
      chk($sformatf("tbl%0d_digits", i), digits_out, e.dig);
      chk($sformatf("tbl%0d_blank", i), blank_out, e.blk);
      chk($sformatf("tbl%0d_valid", i), valid_out, e.vld);
      chk($sformatf("tbl%0d_err", i), decode_err, 0);
    end
    chk("partial_no_frame", fd_cnt, 0);
    hit_reset();
    fd0 = fd_cnt;
    for (int k = 0; k < 7; k++) scan(k, k, 100);
    chk("frame_not_early", fd_cnt, fd0);
    scan(7, 7, 100);
    chk("frame_once", fd_cnt, fd0 + 1);
    chk("frame_digits", digits_out, 32'h7654_3210);
    chk("frame_valid", valid_out, 8'hFF);
    chk("frame_blank", blank_out, 0);
    drive(8'hFC, PAT[2], 30);
    chk("multi_an_err", decode_err, 1);
    chk("multi_an_digits", digits_out, 32'h7654_3210);
`ifdef SEG_ERR_CNT_EN
    chk("err_count_1", err_count, 1);
`endif
    drive(8'hFE, 7'h55, 30);
    chk("bad_seg_err", decode_err, 1);
    chk("bad_seg_digits", digits_out, 32'h7654_3210);
    chk("bad_seg_blank", blank_out, 0);
`ifdef SEG_ERR_CNT_EN
    chk("err_count_2", err_count, 2);
`endif
    drive(8'hFF, 7'h7F, 30);
    chk("err_sticky", decode_err, 1);
    drive(8'hFE, PAT[0], 30);
    drive(8'hFF, 7'h7F, 200);
    chk("stale_not_yet", stale, 0);
    repeat (150) @(negedge clk);
    chk("stale_set", stale, 1);
    drive(8'hFD, PAT[9], 17);
    chk("stale_hold", stale, 1);
    @(negedge clk);
    chk("stale_drop", stale, 0);
    chk("resume_digit", digits_out[7:4], 4'h9);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) scan(k, 1, 30);
    hit_reset();
    fd0 = fd_cnt;
    for (int k = 4; k < 8; k++) scan(k, k + 8, 40);
    chk("reset_drops_seen", fd_cnt, fd0);
    for (int k = 0; k < 4; k++) scan(k, k + 8, 40);
    chk("new_frame_once", fd_cnt, fd0 + 1);
    chk("new_frame_digits", digits_out, 32'hFEDC_BA98);
    chk("new_frame_valid", valid_out, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed seven-segment interface (SEG/AN) that the stopwatch top drives.
- Samples the active-low anode and segment lines and waits for each scan slot to settle.
- Decodes the lit pattern back to a 4-bit hex value per digit and publishes a full 8-digit frame.
- Used as a self-checking monitor in stopwatch benches and as a loopback checker on the board.

Parameters:
- NUM_DIGITS, 8: number of anodes/digit slots.
- SETTLE_CYCLES, 16: cycles {an,seg} must hold unchanged before a sample is taken.
- TIMEOUT_CYCLES, 2000000: cycles with no successful capture before stale asserts (20 ms at 100 MHz).

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- an_in  input  NUM_DIGITS  anode lines, active-low.
- digits_out  output  4*NUM_DIGITS  decoded hex per digit; digit k is at [4k+3:4k].
- blank_out  output  NUM_DIGITS  digit k was last captured with all segments off (7'h7F).
- valid_out  output  NUM_DIGITS  digit k captured at least once since reset.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse.
- decode_err  output  1  sticky; cleared only by reset.
- stale  output  1  no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset (async assert, sync deassert via the reset flop): digits_out=0, blank_out=0, valid_out=0, frame_done=0, decode_err=0, stale=0.
- Reset also clears the seen mask, the settle counter and the timeout counter; synchronizers load all-ones (idle, nothing lit).
- Inputs pass through a 2-flop synchronizer; all logic below uses the synchronized {an_s,seg_s}.
- Settle counter:
  - Clears to 0 on any change of {an_s,seg_s}; otherwise increments, saturating at SETTLE_CYCLES-1.
  - A one-bit "taken" flag clears on change; a capture fires only when the counter is at SETTLE_CYCLES-1 and taken=0, then sets taken. One capture per stable window.
- Capture rules:
  - an_s all-ones: no capture (blanking interval); no error.
  - Exactly one an_s bit low (index k): seg_s=7'h7F sets blank_out[k]=1 and leaves digits_out[k] unchanged. A legal pattern writes the hex value, sets blank_out[k]=0, and sets valid_out[k] and seen[k].
  - Illegal segment pattern, or more than one anode low: decode_err=1; no digit or mask update.
  - Blank and legal captures both set valid_out[k] and seen[k]; an illegal pattern sets neither.
- Latency: a digit updates SETTLE_CYCLES+2 cycles after the inputs change (2 sync + settle).
- Frame:
  - When the seen mask becomes all-ones, frame_done pulses high on the next cycle and seen clears in that same cycle.
  - A capture landing in the clearing cycle is kept in the new mask (the set wins over the clear for that bit).
- Stale: a counter counts cycles since the last successful capture and saturates at TIMEOUT_CYCLES; stale=1 while saturated. Any successful capture zeroes the counter and drops stale on the next cycle.
- Reset mid-scan discards partial-frame state immediately.

Optional Feature:
- Macro SEG_ERR_CNT_EN.
- Defined: adds output err_count (8 bits), which increments on every decode_err event, saturates at 255 and resets to 0.
- Undefined: the port and counter are absent; decode_err behaviour is identical.

Decomposition:
- Package seg_pkg holds the 16-entry active-low pattern constants, with bit order {g,f,e,d,c,b,a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - SEG_BLANK=7F
  - a decode function returning {legal, hex}.
- One sub-module, seg_settle_filter, holds the synchronizer, settle counter and taken flag, and emits a single-cycle sample strobe with {an,seg}.

Test Plan:
- Reset, then hold an_in=8'hFF, seg_in=7'h7F for 100 cycles -> all outputs 0; no capture; no error.
- an_in=8'hFE, seg_in=7'h24 held 20 cycles -> digits_out[3:0]=2 and valid_out[0]=1 at cycle 18. A 10-cycle glitch before this sequence produces no capture.
- Scan digits 0..7 with patterns for values 0..7, 1000 cycles each -> digits_out=32'h76543210, valid_out=8'hFF, and exactly one frame_done pulse after digit 7 settles.
- an_in=8'hFC (two anodes low), then separately seg_in=7'h55 on one anode -> decode_err=1 and sticky; digits unchanged; err_count=2 when SEG_ERR_CNT_EN is defined.
- Scan a frame, then freeze an_in=8'hFF for 2000000 cycles -> stale=1. Resume scanning -> stale=0 one cycle after the next capture.
- Assert reset mid-frame after 4 captures -> outputs clear at once. A new full scan then yields exactly one frame_done.
